uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8-bit asynchronous serial receiver, 8N1 frame format: idle-high line, one start bit, 8 data bits LSB first, one stop bit.
- Receive-side counterpart to the team's baud-rate clock divider and serial transmit path.
- Runs on the system clock. Oversamples the line with an internal tick enable; no derived clock.
- Delivers each byte as a one-cycle valid pulse with error flags.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, ticks per bit. Must be even and ≥ 8.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) = 651, clock cycles per tick (derived localparam).

Ports:
- clock_in  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clock_in.
- rx_data  output  8  last received byte. Holds its value until the next frame completes.
- rx_valid  output  1  one-cycle pulse: good frame received.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch. Tied 0 without PARITY_EN.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - rx_data=0x00; rx_valid, frame_err, parity_err, busy = 0.
  - State IDLE, both synchronizer flops = 1, all counters = 0.
  - Reset asserted mid-frame aborts the frame with no pulses.
- Synchronizer: rx passes through 2 flops; the FSM sees rx_s only.
- Tick divider:
  - Counts 0..DIV-1 and pulses tick when count == DIV-1.
  - Held at 0 in IDLE, so bit timing is referenced to start detection.
- Sample counter: 0..OVERSAMPLE-1, advances on tick.
- FSM states:
  - IDLE: rx_s==0 → START, clear counters.
  - START: on the (OVERSAMPLE/2)th tick (mid-bit), re-sample. rx_s==1 → IDLE (glitch reject, no pulses); rx_s==0 → DATA, clear sample counter.
  - DATA: every OVERSAMPLE ticks, shift rx_s into the MSB of an 8-bit shift register (LSB first on the line). After 8 bits → PARITY if enabled, else STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s==1: load rx_data, pulse rx_valid → IDLE.
    - rx_s==0: load rx_data, pulse frame_err, rx_valid stays 0 → BRK.
  - BRK: wait for rx_s==1 → IDLE. Prevents a break condition from being read as a new start bit.
- Timing: stop-bit sample occurs (OVERSAMPLE/2 + 9*OVERSAMPLE)*DIV = 98952 cycles after the detection cycle. Outputs are registered and visible 1 cycle later.
- Simultaneous events: if frame_err and parity_err both apply, both pulse in the same cycle and rx_valid stays 0.
- No backpressure: a new byte overwrites rx_data. The consumer must capture it on rx_valid.
- A start edge arriving in the cycle IDLE is entered is detected normally. Back-to-back frames need no idle gap.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; one bit is sampled after OVERSAMPLE ticks.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0. Otherwise parity_err pulses at the stop sample and rx_valid is suppressed.
  - Frame is 11 bits. Stop sample moves to 10.5 bit times (109368 cycles).
- Undefined: no PARITY state; parity_err is constant 0.

Decomposition:
- Package uart_pkg:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BRK}.
  - Default constants CLK_FREQ_DEF, BAUD_DEF, OVERSAMPLE_DEF.
  - Function calc_div(clk, baud, os).
- Sub-module uart_rx_tick_gen (ports: clock_in, rst, clr, tick). Parameterised by DIV. Shareable with a future oversampled transmitter.

Test Plan:
- Send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) at 10416 cycles/bit → one rx_valid pulse, rx_data=0xA5, frame_err=0, busy falls with the pulse.
- rx low for 3000 cycles, then high (< 5208 half-bit) → no pulses, FSM returns to IDLE, rx_data unchanged.
- Frame 0x3C with stop bit driven 0, line held low 20000 more cycles → frame_err pulse once, rx_valid=0, rx_data=0x3C, busy held until rx returns high.
- Back-to-back 0x00 then 0xFF, no idle gap → two rx_valid pulses ~104160 cycles apart, data 0x00 then 0xFF.
- Assert rst for 3 cycles during bit 4 of 0x55, then send 0x81 cleanly → no pulse for the aborted frame, then rx_valid with rx_data=0x81.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 → rx_valid, data 0x07. Same byte with parity bit 0 → parity_err, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared types, default constants and divider helper for the UART.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } rx_state_t;

    localparam int CLK_FREQ_DEF   = 100_000_000;
    localparam int BAUD_DEF       = 9600;
    localparam int OVERSAMPLE_DEF = 16;

    // Clock cycles per oversampling tick.
    function automatic int calc_div(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_rx_tick_gen
// Brief   : Oversampling tick divider; one-cycle tick every DIV clocks, held
//           at zero while clr is high.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_rx_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clock_in,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || (r_count == c_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cw'(1);
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_rx
// Brief   : 8N1 oversampling serial receiver with one-cycle valid/error
//           pulses. Define UART_RX_PARITY_EN for an even-parity bit.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clock_in,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int              c_div       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int              c_sw        = $clog2(OVERSAMPLE);
    localparam logic [c_sw-1:0] c_os_last   = c_sw'(OVERSAMPLE - 1);
    localparam logic [c_sw-1:0] c_half_last = c_sw'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] c_st_idle  = IDLE;
    localparam logic [2:0] c_st_start = START;
    localparam logic [2:0] c_st_data  = DATA;
    localparam logic [2:0] c_st_stop  = STOP;
    localparam logic [2:0] c_st_brk   = BRK;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_st_parity     = PARITY;
    localparam logic [2:0] c_st_after_data = PARITY;
`else
    localparam logic [2:0] c_st_after_data = STOP;
`endif

    logic [1:0]      r_sync;
    logic [2:0]      r_state;
    logic [c_sw-1:0] r_samp;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_frame_err;
    logic            w_rx_s;
    logic            w_tick;
    logic            w_bit_end;
    logic            w_par_bad;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx_s    = r_sync[1];
    assign w_bit_end = (r_samp == c_os_last);

    uart_rx_tick_gen #(
        .DIV (c_div)
    ) u_tick_gen (
        .clock_in (clock_in),
        .rst      (rst),
        .clr      (r_state == c_st_idle),
        .tick     (w_tick)
    );

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_samp      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_samp <= '0;
                    r_bit  <= '0;
                    if (!w_rx_s) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_tick) begin
                        if (r_samp == c_half_last) begin
                            // Mid-start-bit recheck rejects short glitches.
                            r_samp  <= '0;
                            r_state <= w_rx_s ? c_st_idle : c_st_data;
                        end else begin
                            r_samp <= r_samp + c_sw'(1);
                        end
                    end
                end
                c_st_data: begin
                    if (w_tick) begin
                        if (w_bit_end) begin
                            r_samp  <= '0;
                            r_shift <= {w_rx_s, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= c_st_after_data;
                            end
                        end else begin
                            r_samp <= r_samp + c_sw'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_st_parity: begin
                    if (w_tick) begin
                        if (w_bit_end) begin
                            r_samp  <= '0;
                            r_state <= c_st_stop;
                        end else begin
                            r_samp <= r_samp + c_sw'(1);
                        end
                    end
                end
`endif
                c_st_stop: begin
                    if (w_tick) begin
                        if (w_bit_end) begin
                            r_samp    <= '0;
                            r_rx_data <= r_shift;
                            if (w_rx_s) begin
                                r_rx_valid <= ~w_par_bad;
                                r_state    <= c_st_idle;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= c_st_brk;
                            end
                        end else begin
                            r_samp <= r_samp + c_sw'(1);
                        end
                    end
                end
                c_st_brk: begin
                    // A held-low line must return high before a new start counts.
                    if (w_rx_s) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            if ((r_state == c_st_parity) && w_tick && w_bit_end) begin
                r_par <= w_rx_s;
            end
            if ((r_state == c_st_stop) && w_tick && w_bit_end) begin
                r_parity_err <= w_par_bad;
            end
        end
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_bad  = ^{r_shift, r_par};
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx against a frame-level line model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT_CYC  = OS * DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS     = PAR ? 11 : 10;
    // Two synchronizer flops plus detection edge, then half a bit plus the
    // remaining frame bits up to mid-stop.
    localparam int LAT       = 3 + (OS / 2 + (NBITS - 1) * OS) * DIV;
    localparam int FRAME_CYC = NBITS * BIT_CYC;

    typedef struct {
        int         cyc;
        logic       v;
        logic       fe;
        logic       pe;
        logic       bz;
        logic [7:0] d;
    } ev_t;

    logic       clock_in = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int  cyc   = 0;
    int  n_vec = 0;
    int  n_err = 0;
    ev_t evq[$];
    ev_t expq[$];
    ev_t mon_e;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clock_in   (clock_in),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    always @(negedge clock_in) begin
        if (rx_valid === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1) begin
            mon_e.cyc = cyc;
            mon_e.v   = rx_valid;
            mon_e.fe  = frame_err;
            mon_e.pe  = parity_err;
            mon_e.bz  = busy;
            mon_e.d   = rx_data;
            evq.push_back(mon_e);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic drive_line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clock_in);
    endtask

    // Drives one frame and queues the outcome the line protocol dictates.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        ev_t e;
        e.cyc = cyc + LAT;
        e.d   = d;
        e.fe  = ~stop_b;
        e.pe  = PAR & par_flip;
        e.v   = stop_b & ~e.pe;
        e.bz  = ~stop_b;
        expq.push_back(e);
        drive_line(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_line(d[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
        drive_line((^d) ^ par_flip, BIT_CYC);
`endif
        drive_line(stop_b, BIT_CYC);
    endtask

    task automatic test_reset();
        n_vec++;
        if ({rx_data, rx_valid, frame_err, parity_err, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %03h expected 000",
                     {rx_data, rx_valid, frame_err, parity_err, busy});
        end
        rst = 1'b0;
        drive_line(1'b1, 20);
        n_vec++;
        if (busy !== 1'b0 || rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b data=%02h expected busy=0 data=00", busy, rx_data);
        end
    endtask

    task automatic test_single();
        evq.delete();
        expq.delete();
        send_frame(8'hA5, 1'b1, 1'b0);
        drive_line(1'b1, 2 * BIT_CYC);
        n_vec++;
        if (evq.size() != expq.size()) begin
            n_err++;
            $display("FAIL single_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        foreach (expq[i]) if (i < evq.size()) begin
            n_vec++;
            if (evq[i].cyc !== expq[i].cyc) begin
                n_err++;
                $display("FAIL single_time: got cycle %0d expected %0d", evq[i].cyc, expq[i].cyc);
            end
            n_vec++;
            if ({evq[i].v, evq[i].fe, evq[i].pe, evq[i].bz, evq[i].d} !==
                {expq[i].v, expq[i].fe, expq[i].pe, expq[i].bz, expq[i].d}) begin
                n_err++;
                $display("FAIL single_event: got v/fe/pe/busy/data=%b%b%b%b/%02h expected %b%b%b%b/%02h",
                         evq[i].v, evq[i].fe, evq[i].pe, evq[i].bz, evq[i].d,
                         expq[i].v, expq[i].fe, expq[i].pe, expq[i].bz, expq[i].d);
            end
        end
        n_vec++;
        if (rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_hold: got data %02h expected a5", rx_data);
        end
    endtask

    task automatic test_glitch();
        evq.delete();
        drive_line(1'b0, 12);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy: got busy %b expected 1", busy);
        end
        drive_line(1'b1, 3 * BIT_CYC);
        n_vec++;
        if (evq.size() != 0 || busy !== 1'b0 || rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL glitch_reject: got events=%0d busy=%b data=%02h expected 0/0/a5",
                     evq.size(), busy, rx_data);
        end
    endtask

    task automatic test_break();
        evq.delete();
        expq.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_line(1'b0, 5 * BIT_CYC);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL break_hold: got busy %b expected 1", busy);
        end
        drive_line(1'b1, 8);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL break_release: got busy %b expected 0", busy);
        end
        drive_line(1'b1, BIT_CYC);
        n_vec++;
        if (evq.size() != expq.size()) begin
            n_err++;
            $display("FAIL break_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        foreach (expq[i]) if (i < evq.size()) begin
            n_vec++;
            if ({evq[i].v, evq[i].fe, evq[i].pe, evq[i].bz, evq[i].d} !==
                {expq[i].v, expq[i].fe, expq[i].pe, expq[i].bz, expq[i].d}) begin
                n_err++;
                $display("FAIL break_event: got v/fe/pe/busy/data=%b%b%b%b/%02h expected %b%b%b%b/%02h",
                         evq[i].v, evq[i].fe, evq[i].pe, evq[i].bz, evq[i].d,
                         expq[i].v, expq[i].fe, expq[i].pe, expq[i].bz, expq[i].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        evq.delete();
        expq.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_line(1'b1, 2 * BIT_CYC);
        n_vec++;
        if (evq.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d events expected 2", evq.size());
        end
        foreach (expq[i]) if (i < evq.size()) begin
            n_vec++;
            if (evq[i].cyc !== expq[i].cyc || evq[i].v !== 1'b1 || evq[i].d !== expq[i].d) begin
                n_err++;
                $display("FAIL b2b_event: got cycle %0d v=%b data %02h expected %0d 1 %02h",
                         evq[i].cyc, evq[i].v, evq[i].d, expq[i].cyc, expq[i].d);
            end
        end
        if (evq.size() == 2) begin
            n_vec++;
            if (evq[1].cyc - evq[0].cyc !== FRAME_CYC) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d cycles expected %0d",
                         evq[1].cyc - evq[0].cyc, FRAME_CYC);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b;
        b = 8'h55;
        evq.delete();
        expq.delete();
        drive_line(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) drive_line(b[i], BIT_CYC);
        drive_line(b[4], BIT_CYC / 2);
        rst = 1'b1;
        drive_line(1'b1, 3);
        n_vec++;
        if ({rx_data, busy} !== 9'h000) begin
            n_err++;
            $display("FAIL abort_reset: got data %02h busy %b expected 00 0", rx_data, busy);
        end
        rst = 1'b0;
        drive_line(1'b1, 2 * BIT_CYC);
        send_frame(8'h81, 1'b1, 1'b0);
        drive_line(1'b1, 2 * BIT_CYC);
        n_vec++;
        if (evq.size() != 1) begin
            n_err++;
            $display("FAIL abort_count: got %0d events expected 1", evq.size());
        end
        foreach (expq[i]) if (i < evq.size()) begin
            n_vec++;
            if (evq[i].cyc !== expq[i].cyc || evq[i].v !== 1'b1 || evq[i].d !== expq[i].d) begin
                n_err++;
                $display("FAIL abort_event: got cycle %0d v=%b data %02h expected %0d 1 %02h",
                         evq[i].cyc, evq[i].v, evq[i].d, expq[i].cyc, expq[i].d);
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        evq.delete();
        expq.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        drive_line(1'b1, BIT_CYC);
        send_frame(8'h07, 1'b1, 1'b1);
        drive_line(1'b1, 2 * BIT_CYC);
        n_vec++;
        if (evq.size() != 2) begin
            n_err++;
            $display("FAIL parity_count: got %0d events expected 2", evq.size());
        end
        foreach (expq[i]) if (i < evq.size()) begin
            n_vec++;
            if ({evq[i].v, evq[i].fe, evq[i].pe, evq[i].d} !==
                {expq[i].v, expq[i].fe, expq[i].pe, expq[i].d}) begin
                n_err++;
                $display("FAIL parity_event: got v/fe/pe/data=%b%b%b/%02h expected %b%b%b/%02h",
                         evq[i].v, evq[i].fe, evq[i].pe, evq[i].d,
                         expq[i].v, expq[i].fe, expq[i].pe, expq[i].d);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic stop_b;
        evq.delete();
        expq.delete();
        for (int n = 0; n < 10; n++) begin
            stop_b = ($urandom_range(0, 3) != 0);
            send_frame(8'($urandom), stop_b, ($urandom_range(0, 3) == 0));
            drive_line(1'b1, stop_b ? $urandom_range(0, 20) : 8 + $urandom_range(0, 20));
        end
        drive_line(1'b1, 2 * BIT_CYC);
        n_vec++;
        if (evq.size() != expq.size()) begin
            n_err++;
            $display("FAIL random_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        foreach (expq[i]) if (i < evq.size()) begin
            n_vec++;
            if (evq[i].cyc !== expq[i].cyc) begin
                n_err++;
                $display("FAIL random_time[%0d]: got cycle %0d expected %0d", i, evq[i].cyc, expq[i].cyc);
            end
            n_vec++;
            if ({evq[i].v, evq[i].fe, evq[i].pe, evq[i].bz, evq[i].d} !==
                {expq[i].v, expq[i].fe, expq[i].pe, expq[i].bz, expq[i].d}) begin
                n_err++;
                $display("FAIL random_event[%0d]: got v/fe/pe/busy/data=%b%b%b%b/%02h expected %b%b%b%b/%02h",
                         i, evq[i].v, evq[i].fe, evq[i].pe, evq[i].bz, evq[i].d,
                         expq[i].v, expq[i].fe, expq[i].pe, expq[i].bz, expq[i].d);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clock_in);
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
